pulse_seq_sched: RTL and testbench
==================================

PULSE_SEQ_SCHED -- requirements
Module: pulse_seq_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, number of pulse channels.
REQ-002 SHALL have parameter CNT_W, default 24, width of the width, gap and timeout counters.
REQ-003 SHALL have parameter ARM_KEY, default 32'hA5A5_5A5A, unlock value.
REQ-004 SHALL have parameter ARM_TIMEOUT, default 1000000, cycles allowed in ARMED.
REQ-005 SHALL have port ACLK, input, 1, sole clock, rising edge.
REQ-006 SHALL have port ARESET, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port arm_wr, input, 1, one-cycle strobe qualifying arm_key.
REQ-008 SHALL have port arm_key, input, 32, unlock word.
REQ-009 SHALL have port fire_req, input, 1, one-cycle fire request.
REQ-010 SHALL have port abort, input, 1, level abort.
REQ-011 SHALL have port clr_fault, input, 1, one-cycle fault clear.
REQ-012 SHALL have port cfg_mask, input, NCH, channels to fire.
REQ-013 SHALL have port cfg_width, input, CNT_W, pulse length in cycles.
REQ-014 SHALL have port cfg_gap, input, CNT_W, idle cycles between pulses.
REQ-015 SHALL have port pulse_out, output, NCH, registered squib drive.
REQ-016 SHALL have port busy, output, 1, high in FIRE or GAP.
REQ-017 SHALL have port done, output, 1, one-cycle sequence-complete pulse.
REQ-018 SHALL have port fault, output, 1, high in FAULT.
REQ-019 SHALL have port state, output, 3, IDLE=0 ARMED=1 FIRE=2 GAP=3 DONE=4 FAULT=5.

Function
REQ-020 IDLE: arm_wr with arm_key==ARM_KEY SHALL go ARMED; arm_wr with any other key SHALL go FAULT; fire_req SHALL be ignored.
REQ-021 ARMED: a timeout counter SHALL start at 0; after ARM_TIMEOUT cycles without fire_req the FSM SHALL return to IDLE with no fault.
REQ-022 ARMED + fire_req: cfg_mask, cfg_width, cfg_gap SHALL be latched that edge; mask==0 or width==0 SHALL go FAULT, else FIRE on the lowest set channel.
REQ-023 pulse_out SHALL assert on the first edge after fire_req is sampled, stay high exactly width cycles, and carry at most one bit high at any time.
REQ-024 After each pulse the channel SHALL be cleared from the latched mask; if bits remain: gap>0 -> GAP for exactly gap cycles (pulse_out all zero), gap==0 -> next channel's pulse starts on the very next cycle.
REQ-025 After the last pulse the FSM SHALL enter DONE for one cycle (done=1), then IDLE; re-arming SHALL be required for another sequence.
REQ-026 Changes of cfg_* after latching SHALL not affect the running sequence.
REQ-027 abort SHALL have top priority: from any state except FAULT it SHALL force IDLE and pulse_out=0 on the next edge; in FAULT it SHALL be ignored.
REQ-028 FAULT: pulse_out=0; only clr_fault (or ARESET) SHALL exit, to IDLE; simultaneous clr_fault and arm_wr SHALL only clear.
REQ-029 arm_wr while ARMED, FIRE or GAP SHALL go FAULT and drop pulse_out next edge.
REQ-030 Counters SHALL never wrap: counting stops at terminal value.

Reset
REQ-031 ARESET high SHALL immediately force state=IDLE, pulse_out=0, busy=0, done=0, fault=0, all counters and latched config 0, including mid-pulse.
REQ-032 Release of ARESET SHALL not, by itself, cause any pulse.

Verification
REQ-033 arm 32'hA5A5_5A5A, fire mask=4'b0101 width=3 gap=2 -> pulse_out[0] cycles 1-3, zero 4-5, pulse_out[2] 6-8, done at cycle 9.
REQ-034 arm_wr key 32'h0 -> fault=1, state=5; fire_req ignored; clr_fault -> state=0.
REQ-035 armed, fire mask=4'b0011 width=2 gap=0 -> ch0 two cycles then ch1 two cycles back-to-back, never both high.
REQ-036 abort in the 2nd cycle of a width=10 pulse -> pulse_out=0 next edge, state=0, done stays 0.
REQ-037 ARM_TIMEOUT=5, arm and no fire -> state returns 0 after 5 cycles; later fire_req produces no pulse.
REQ-038 ARESET asserted mid-GAP -> all outputs 0 asynchronously; no pulse after release.

Source files
------------

// File: rtl/pulse_seq_sched_if.sv
// rtl/pulse_seq_sched_if.sv - control/status bundle for the pulse sequence scheduler
//
// Purpose: groups the arm/fire/abort controls, sequence configuration and
// status outputs of pulse_seq_sched into one interface.
// Signals:
//   arm_wr, arm_key   : one-cycle arm strobe and its 32-bit unlock word
//   fire_req          : one-cycle fire request
//   abort             : level abort
//   clr_fault         : one-cycle fault clear
//   cfg_mask          : NCH channels to fire
//   cfg_width/cfg_gap : pulse length / inter-pulse idle cycles
//   pulse_out         : registered squib drive, at most one bit high
//   busy, done, fault : status flags
//   state             : IDLE=0 ARMED=1 FIRE=2 GAP=3 DONE=4 FAULT=5
// Modports: master drives controls and config, slave (the scheduler) drives status.
interface pulse_seq_sched_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 24
);
  logic             arm_wr;
  logic [31:0]      arm_key;
  logic             fire_req;
  logic             abort;
  logic             clr_fault;
  logic [NCH-1:0]   cfg_mask;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_gap;
  logic [NCH-1:0]   pulse_out;
  logic             busy;
  logic             done;
  logic             fault;
  logic [2:0]       state;

  modport master (
    output arm_wr, arm_key, fire_req, abort, clr_fault,
           cfg_mask, cfg_width, cfg_gap,
    input  pulse_out, busy, done, fault, state
  );

  modport slave (
    input  arm_wr, arm_key, fire_req, abort, clr_fault,
           cfg_mask, cfg_width, cfg_gap,
    output pulse_out, busy, done, fault, state
  );
endinterface

// File: rtl/pulse_seq_sched.sv
// rtl/pulse_seq_sched.sv - armed, keyed multi-channel pulse sequence scheduler
//
// Purpose: after a keyed arm and a fire request, drives one pulse of
// cfg_width cycles on each channel set in cfg_mask, lowest channel first,
// separated by cfg_gap idle cycles, then reports done for one cycle.
// Ports:
//   ACLK   : sole clock, rising edge
//   ARESET : asynchronous active-high reset
//   bus    : pulse_seq_sched_if slave modport (controls, config, status)
module pulse_seq_sched #(
  parameter int          NCH         = 4,
  parameter int          CNT_W       = 24,
  parameter logic [31:0] ARM_KEY     = 32'hA5A5_5A5A,
  parameter int          ARM_TIMEOUT = 1000000
) (
  input  logic              ACLK,
  input  logic              ARESET,
  pulse_seq_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_FIRE  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [NCH-1:0]   pulse_q, pulse_d;

  logic [CNT_W-1:0] cnt_inc;
  logic [32:0]      cnt_ext;
  logic [NCH-1:0]   cur_ch;
  logic [NCH-1:0]   rem_mask;
  logic [NCH-1:0]   nxt_ch;
  logic [NCH-1:0]   first_ch;

  // One shared counter serves the ARMED timeout, pulse width and gap.
  // It restarts at 0 on every state/channel change; cnt_ext is the number of
  // cycles the current phase will have lasted after this edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    width_d  = width_q;
    gap_d    = gap_q;
    pulse_d  = '0;
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    cnt_ext  = 33'(cnt_q) + 33'd1;
    // x & -x isolates the lowest set bit: the channel currently being served.
    cur_ch   = mask_q & (~mask_q + NCH'(1));
    rem_mask = mask_q & ~cur_ch;
    nxt_ch   = rem_mask & (~rem_mask + NCH'(1));
    first_ch = bus.cfg_mask & (~bus.cfg_mask + NCH'(1));

    if (bus.abort && state_q != S_FAULT) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.arm_wr) begin
            cnt_d   = '0;
            state_d = (bus.arm_key == ARM_KEY) ? S_ARMED : S_FAULT;
          end
        end
        S_ARMED: begin
          if (bus.arm_wr) begin
            state_d = S_FAULT;
          end else if (bus.fire_req) begin
            mask_d  = bus.cfg_mask;
            width_d = bus.cfg_width;
            gap_d   = bus.cfg_gap;
            cnt_d   = '0;
            if (bus.cfg_mask == '0 || bus.cfg_width == '0) begin
              state_d = S_FAULT;
            end else begin
              state_d = S_FIRE;
              pulse_d = first_ch;
            end
          end else if (cnt_ext >= 33'(ARM_TIMEOUT)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_FIRE: begin
          if (bus.arm_wr) begin
            state_d = S_FAULT;
          end else if (cnt_ext >= 33'(width_q)) begin
            mask_d = rem_mask;
            cnt_d  = '0;
            if (rem_mask == '0) begin
              state_d = S_DONE;
            end else if (gap_q == '0) begin
              // Back-to-back: next channel takes over on the same edge.
              state_d = S_FIRE;
              pulse_d = nxt_ch;
            end else begin
              state_d = S_GAP;
            end
          end else begin
            cnt_d   = cnt_inc;
            pulse_d = cur_ch;
          end
        end
        S_GAP: begin
          if (bus.arm_wr) begin
            state_d = S_FAULT;
          end else if (cnt_ext >= 33'(gap_q)) begin
            state_d = S_FIRE;
            cnt_d   = '0;
            pulse_d = cur_ch;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        S_FAULT: begin
          // clr_fault wins over a coincident arm_wr.
          if (bus.clr_fault) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      width_q <= '0;
      gap_q   <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      width_q <= width_d;
      gap_q   <= gap_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.state     = state_q;
  assign bus.busy      = (state_q == S_FIRE) || (state_q == S_GAP);
  assign bus.done      = (state_q == S_DONE);
  assign bus.fault     = (state_q == S_FAULT);

endmodule

// File: tb/tb_pulse_seq_sched.sv
// tb/tb_pulse_seq_sched.sv - self-checking bench for pulse_seq_sched
module tb_pulse_seq_sched;
  localparam int          NCH   = 4;
  localparam int          CNT_W = 8;
  localparam logic [31:0] KEY   = 32'hA5A5_5A5A;

  logic ACLK;
  logic ARESET;
  int   checks;
  int   failures;

  pulse_seq_sched_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

  pulse_seq_sched #(
    .NCH(NCH), .CNT_W(CNT_W), .ARM_KEY(KEY), .ARM_TIMEOUT(5)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .bus(bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.arm_wr    = 1'b0;
    bus.arm_key   = 32'h0;
    bus.fire_req  = 1'b0;
    bus.abort     = 1'b0;
    bus.clr_fault = 1'b0;
  endtask

  task automatic scramble_cfg();
    bus.cfg_mask  = NCH'($urandom);
    bus.cfg_width = CNT_W'($urandom);
    bus.cfg_gap   = CNT_W'($urandom);
  endtask

  task automatic arm(input logic [31:0] key);
    bus.arm_wr  = 1'b1;
    bus.arm_key = key;
    tick();
    bus.arm_wr  = 1'b0;
  endtask

  // Reference: expected pulse_out per cycle after fire, from the sequencing rules.
  task automatic build_model(input logic [NCH-1:0] mask, input int width, input int gap,
                             output logic [NCH-1:0] q[$]);
    bit first;
    q = {};
    first = 1'b1;
    for (int ch = 0; ch < NCH; ch++) begin
      if (mask[ch]) begin
        if (!first) for (int g = 0; g < gap; g++) q.push_back('0);
        for (int w = 0; w < width; w++) q.push_back(NCH'(1) << ch);
        first = 1'b0;
      end
    end
  endtask

  task automatic run_seq(input string tag, input logic [NCH-1:0] mask, input int width, input int gap);
    logic [NCH-1:0] q[$];
    arm(KEY);
    chk({tag, ".armed"}, 32'(bus.state), 32'd1);
    bus.cfg_mask  = mask;
    bus.cfg_width = CNT_W'(width);
    bus.cfg_gap   = CNT_W'(gap);
    bus.fire_req  = 1'b1;
    build_model(mask, width, gap, q);
    tick();
    bus.fire_req  = 1'b0;
    foreach (q[i]) begin
      chk({tag, ".pulse"}, 32'(bus.pulse_out), 32'(q[i]));
      chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
      chk({tag, ".onehot"}, 32'($countones(bus.pulse_out) <= 1), 32'd1);
      scramble_cfg();
      tick();
    end
    chk({tag, ".done"}, 32'(bus.done), 32'd1);
    chk({tag, ".done_state"}, 32'(bus.state), 32'd4);
    chk({tag, ".done_pulse"}, 32'(bus.pulse_out), 32'd0);
    tick();
    chk({tag, ".idle"}, 32'(bus.state), 32'd0);
    chk({tag, ".done_clr"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ARESET   = 1'b1;
    idle_inputs();
    bus.cfg_mask  = '0;
    bus.cfg_width = '0;
    bus.cfg_gap   = '0;
    tick();
    tick();
    chk("rst.state", 32'(bus.state), 32'd0);
    chk("rst.pulse", 32'(bus.pulse_out), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.fault", 32'(bus.fault), 32'd0);
    ARESET = 1'b0;
    tick();
    chk("rel.pulse", 32'(bus.pulse_out), 32'd0);

    // Directed sequences from the requirement examples.
    run_seq("seq0101", 4'b0101, 3, 2);
    run_seq("seq0011", 4'b0011, 2, 0);

    // No re-fire without re-arming.
    bus.fire_req = 1'b1;
    tick();
    bus.fire_req = 1'b0;
    tick();
    chk("norearm.pulse", 32'(bus.pulse_out), 32'd0);
    chk("norearm.state", 32'(bus.state), 32'd0);

    // Bad key -> FAULT; fire ignored; clr beats arm.
    arm(32'h0);
    chk("badkey.fault", 32'(bus.fault), 32'd1);
    chk("badkey.state", 32'(bus.state), 32'd5);
    bus.fire_req = 1'b1;
    bus.abort    = 1'b1;
    tick();
    bus.fire_req = 1'b0;
    bus.abort    = 1'b0;
    chk("fault.sticky", 32'(bus.state), 32'd5);
    chk("fault.pulse", 32'(bus.pulse_out), 32'd0);
    bus.clr_fault = 1'b1;
    bus.arm_wr    = 1'b1;
    bus.arm_key   = KEY;
    tick();
    idle_inputs();
    chk("clr.state", 32'(bus.state), 32'd0);
    chk("clr.fault", 32'(bus.fault), 32'd0);

    // Abort in 2nd cycle of a long pulse.
    arm(KEY);
    bus.cfg_mask  = 4'b0001;
    bus.cfg_width = 8'd10;
    bus.cfg_gap   = 8'd0;
    bus.fire_req  = 1'b1;
    tick();
    bus.fire_req  = 1'b0;
    chk("abort.c1", 32'(bus.pulse_out), 32'd1);
    tick();
    chk("abort.c2", 32'(bus.pulse_out), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort.pulse", 32'(bus.pulse_out), 32'd0);
    chk("abort.state", 32'(bus.state), 32'd0);
    chk("abort.done", 32'(bus.done), 32'd0);
    tick();
    chk("abort.done2", 32'(bus.done), 32'd0);

    // ARMED timeout after 5 cycles.
    arm(KEY);
    for (int i = 1; i < 5; i++) begin
      chk("tmo.armed", 32'(bus.state), 32'd1);
      tick();
    end
    chk("tmo.last", 32'(bus.state), 32'd1);
    tick();
    chk("tmo.idle", 32'(bus.state), 32'd0);
    chk("tmo.nofault", 32'(bus.fault), 32'd0);
    bus.cfg_mask  = 4'b0001;
    bus.cfg_width = 8'd2;
    bus.fire_req  = 1'b1;
    tick();
    bus.fire_req  = 1'b0;
    chk("tmo.nopulse", 32'(bus.pulse_out), 32'd0);

    // Async reset mid-GAP.
    arm(KEY);
    bus.cfg_mask  = 4'b0101;
    bus.cfg_width = 8'd2;
    bus.cfg_gap   = 8'd4;
    bus.fire_req  = 1'b1;
    tick();
    bus.fire_req  = 1'b0;
    tick();
    tick();
    chk("gap.state", 32'(bus.state), 32'd3);
    #2;
    ARESET = 1'b1;
    #1;
    chk("arst.state", 32'(bus.state), 32'd0);
    chk("arst.pulse", 32'(bus.pulse_out), 32'd0);
    chk("arst.busy", 32'(bus.busy), 32'd0);
    tick();
    ARESET = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("arst.nopulse", 32'(bus.pulse_out), 32'd0);
    end

    // arm_wr during FIRE -> FAULT, pulse dropped.
    arm(KEY);
    bus.cfg_mask  = 4'b1000;
    bus.cfg_width = 8'd5;
    bus.fire_req  = 1'b1;
    tick();
    bus.fire_req  = 1'b0;
    chk("rearm.c1", 32'(bus.pulse_out), 32'd8);
    arm(KEY);
    chk("rearm.fault", 32'(bus.state), 32'd5);
    chk("rearm.pulse", 32'(bus.pulse_out), 32'd0);
    bus.clr_fault = 1'b1;
    tick();
    bus.clr_fault = 1'b0;

    // Zero mask / zero width -> FAULT.
    arm(KEY);
    bus.cfg_mask  = 4'b0000;
    bus.cfg_width = 8'd3;
    bus.fire_req  = 1'b1;
    tick();
    bus.fire_req  = 1'b0;
    chk("mask0.state", 32'(bus.state), 32'd5);
    bus.clr_fault = 1'b1;
    tick();
    bus.clr_fault = 1'b0;
    arm(KEY);
    bus.cfg_mask  = 4'b0110;
    bus.cfg_width = 8'd0;
    bus.fire_req  = 1'b1;
    tick();
    bus.fire_req  = 1'b0;
    chk("width0.state", 32'(bus.state), 32'd5);
    chk("width0.pulse", 32'(bus.pulse_out), 32'd0);
    bus.clr_fault = 1'b1;
    tick();
    bus.clr_fault = 1'b0;

    // Randomized sequences against the reference model.
    for (int n = 0; n < 20; n++) begin
      logic [NCH-1:0] m;
      m = NCH'($urandom_range(1, (1 << NCH) - 1));
      run_seq("rand", m, int'($urandom_range(1, 5)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
